// File: rtl/multiword_sub_sequencer_if.sv
// Handshake/bus bundle for multiword_sub_sequencer.
// master: operand producer / result consumer side; slave: the sequencer.
interface multiword_sub_sequencer_if #(
    parameter int SLICES = 4
);
    localparam int W = 6 * SLICES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, busy
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, busy
    );
endinterface

// File: rtl/multiword_sub_sequencer.sv
// multiword_sub_sequencer: wide subtractor (6*SLICES bits) built from one
// 6-bit ripple-borrow slice reused once per cycle, LSB slice first, with the
// borrow carried between slices in a register.
// Optional build macro SUB_SAT_EN: when defined, a final borrow forces diff
// to zero (unsigned saturating subtract); bout still reports the borrow.

// 6-bit ripple-borrow subtractor: d = a - b - bin, bout = borrow out of bit 5.
module ripple_borrow_subtractor_6bit (
    input  logic [5:0] a,
    input  logic [5:0] b,
    input  logic       bin,
    output logic [5:0] d,
    output logic       bout
);
    logic [6:0] br;

    assign br[0] = bin;

    for (genvar gi = 0; gi < 6; gi++) begin : g_bit
        // Full subtractor cell: borrow when a < b + borrow_in at this bit
        assign d[gi]    = a[gi] ^ b[gi] ^ br[gi];
        assign br[gi+1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & br[gi]);
    end

    assign bout = br[6];
endmodule

module multiword_sub_sequencer #(
    parameter int SLICES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multiword_sub_sequencer_if.slave bus
);
    localparam int W     = 6 * SLICES;
    localparam int IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;
    // Slice mux is padded to a power of two so any idx value selects a
    // defined entry; idx itself never goes past SLICES-1.
    localparam int NPAD  = 1 << IDX_W;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SLICES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               borrow_q, borrow_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;

    logic [5:0]         a_sl [NPAD];
    logic [5:0]         b_sl [NPAD];
    logic [5:0]         sub_a;
    logic [5:0]         sub_b;
    logic [5:0]         sub_d;
    logic               sub_bout;

    for (genvar gi = 0; gi < NPAD; gi++) begin : g_slice
        if (gi < SLICES) begin : g_real
            assign a_sl[gi] = a_q[6*gi +: 6];
            assign b_sl[gi] = b_q[6*gi +: 6];
        end else begin : g_pad
            assign a_sl[gi] = '0;
            assign b_sl[gi] = '0;
        end
    end

    assign sub_a = a_sl[idx_q];
    assign sub_b = b_sl[idx_q];

    ripple_borrow_subtractor_6bit u_sub (
        .a    (sub_a),
        .b    (sub_b),
        .bin  (borrow_q),
        .d    (sub_d),
        .bout (sub_bout)
    );

    // Next-state and registered-output computation for the IDLE/RUN/DONE FSM
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        borrow_d    = borrow_q;
        a_d         = a_q;
        b_d         = b_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d        = bus.a;
                    b_d        = bus.b;
                    borrow_d   = bus.bin;
                    idx_d      = '0;
                    state_d    = S_RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_RUN: begin
                // Only the current slice of diff is updated; others hold.
                for (int i = 0; i < SLICES; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        diff_d[6*i +: 6] = sub_d;
                    end
                end
                borrow_d = sub_bout;
                if (idx_q == IDX_LAST) begin
                    bout_d      = sub_bout;
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
`ifdef SUB_SAT_EN
                    if (sub_bout) begin
                        diff_d = '0;
                    end
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            borrow_q    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            borrow_q    <= borrow_d;
            a_q         <= a_d;
            b_q         <= b_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.busy      = busy_q;
endmodule
